spi_byte_engine: RTL and testbench
==================================

# spi_byte_engine

Byte-level SPI mode-0 master engine sitting directly downstream of the joystick transfer controller in the Snake design. It accepts one byte plus a start request from the controller, generates SCLK, shifts the byte out on MOSI MSB-first while capturing MISO, then returns the received byte with a BUSY handshake. The controller owns SS and byte sequencing. This block owns only single-byte serialization and the inter-byte gap.

## Interface
- HALF_PER, 1: CLK cycles per SCLK half-period. Minimum 1.
- GAP_CYC, 1: extra CLK cycles BUSY stays high after the 8th SCLK falling edge. 0 is allowed.
- CLK  input  1  system clock (66.67 kHz in the Snake build); all logic on posedge.
- RST  input  1  asynchronous, active-low reset.
- getByte  input  1  transfer request, level-sensitive, sampled only in IDLE.
- sndData  input  8  byte to transmit, latched when the request is accepted.
- MISO  input  1  serial data from slave.
- BUSY  output  1  high from acceptance until the transfer and gap complete.
- RxData  output  8  last fully received byte.
- MOSI  output  1  serial data to slave.
- SCLK  output  1  serial clock, idles low (CPOL=0).

## Operation
- Reset values (applied immediately when RST goes low): BUSY=0, RxData=8'h00, MOSI=0, SCLK=0, state=IDLE, shift registers and counters cleared.
- States:
  - IDLE: BUSY=0, SCLK=0, MOSI=0. If getByte=1 at posedge: latch sndData into tx shift register, set MOSI=sndData[7] and BUSY=1, clear the half-period and bit counters, then go to SHIFT.
  - SHIFT: toggle SCLK every HALF_PER cycles.
    - On each rising toggle, shift MISO into the rx register LSB.
    - On each falling toggle, advance MOSI to the next lower tx bit.
    - After the 8th falling toggle, copy rx into RxData, drive MOSI=0, then go to GAP, or to IDLE with BUSY=0 when GAP_CYC=0.
  - GAP: hold SCLK=0 and BUSY=1 for GAP_CYC cycles, then go to IDLE with BUSY=0.
- Bit order is MSB first in both directions. The first bit received lands in RxData[7].
- getByte during SHIFT or GAP is ignored. sndData changes after acceptance are ignored.
- If getByte is still high when IDLE is re-entered, a new transfer starts at the next posedge. Back-to-back transfers are legal.
- RxData changes only at the end of a complete byte. An aborted byte never updates it.
- Reset mid-transfer: all outputs return to reset values asynchronously, and the partial byte is discarded.

## Timing
- Edge 0 is the posedge where IDLE samples getByte=1. At edge 0: BUSY rises and MOSI=sndData[7].
- SCLK rising edges occur at edges (2k+1)·HALF_PER and falling edges at (2k+2)·HALF_PER, for k=0..7.
- MISO is sampled at each rising edge. MOSI changes only at falling edges, so it is stable for one full SCLK half-period before every rising edge.
- RxData updates at edge 16·HALF_PER.
- BUSY falls at edge 16·HALF_PER+GAP_CYC, so it is high for exactly 16·HALF_PER+GAP_CYC cycles.
- The earliest next acceptance is one edge after BUSY falls.
- The controller samples BUSY on negedge, and the half-cycle offset is safe because all outputs here are posedge registers.

## Configuration
- SPI_LOOPBACK_EN
  - Defined: MISO is ignored and the rx shifter samples the internal MOSI at each rising SCLK, so after every transfer RxData equals the transmitted byte. This is used for board bring-up without the joystick attached.
  - Undefined: MISO is used as described above.
  - Timing is identical in both builds.

## Test plan
- Reset: hold RST=0 with random inputs. BUSY=0, SCLK=0, MOSI=0 and RxData=8'h00 immediately and throughout.
- Single byte (HALF_PER=1, GAP_CYC=1): send sndData=8'hA5 with the slave model returning 8'h3C.
  - MOSI sampled at SCLK rises reads 1,0,1,0,0,1,0,1.
  - RxData=8'h3C at edge 16.
  - BUSY is high for exactly 17 cycles.
- Controller-style sequence of 5 bytes (8'h80,0,0,0,0) with the slave returning 8'h12,34,56,78,9A. Every byte is captured correctly and each BUSY pulse has the same length.
- Ignored inputs: toggle getByte and change sndData to 8'hFF during SHIFT. The transfer completes with the original byte, and no extra transfer starts if getByte is low when IDLE is re-entered.
- Abort: drive RST=0 after the 3rd SCLK rise.
  - Outputs reset immediately and RxData keeps 8'h00.
  - A following transfer of 8'h5A with the slave returning 8'hC3 yields RxData=8'hC3.
- With SPI_LOOPBACK_EN defined and MISO tied to 1, sending 8'h6E yields RxData=8'h6E. Also cover HALF_PER=3, GAP_CYC=0: BUSY is high for 48 cycles.

Source files
------------

// File: rtl/spi_byte_engine_if.sv
// Handshake and SPI pin bundle between the byte engine, its controller and the slave.
// The engine takes the slave modport; the controller/slave side takes master.
interface spi_byte_engine_if;
  logic       getByte;
  logic [7:0] sndData;
  logic       MISO;
  logic       BUSY;
  logic [7:0] RxData;
  logic       MOSI;
  logic       SCLK;

  modport slave (
    input  getByte, sndData, MISO,
    output BUSY, RxData, MOSI, SCLK
  );

  modport master (
    output getByte, sndData, MISO,
    input  BUSY, RxData, MOSI, SCLK
  );
endinterface

// File: rtl/spi_byte_engine.sv
// SPI mode-0 single-byte master: MSB-first shift out on MOSI, capture on MISO, BUSY handshake.
// Build option SPI_LOOPBACK_EN: the rx shifter samples the internal MOSI instead of MISO.
module spi_byte_engine #(
  parameter int HALF_PER = 1,
  parameter int GAP_CYC  = 1
) (
  input  logic              CLK,
  input  logic              RST,
  spi_byte_engine_if.slave  bus
);

  localparam int HW = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
  localparam int GW = (GAP_CYC  > 1) ? $clog2(GAP_CYC)  : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PER - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t        state,    state_nxt;
  logic [HW-1:0] half_cnt, half_cnt_nxt;
  logic [2:0]    bit_cnt,  bit_cnt_nxt;
  logic [GW-1:0] gap_cnt,  gap_cnt_nxt;
  logic [6:0]    tx_sr,    tx_sr_nxt;    // bits still to send after the one on MOSI
  logic [7:0]    rx_sr,    rx_sr_nxt;
  logic [7:0]    rx_data,  rx_data_nxt;
  logic          mosi,     mosi_nxt;
  logic          sclk,     sclk_nxt;
  logic          busy,     busy_nxt;
  logic          rx_bit;

`ifdef SPI_LOOPBACK_EN
  assign rx_bit = mosi;
`else
  assign rx_bit = bus.MISO;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      half_cnt <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      mosi     <= 1'b0;
      sclk     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      half_cnt <= half_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      tx_sr    <= tx_sr_nxt;
      rx_sr    <= rx_sr_nxt;
      rx_data  <= rx_data_nxt;
      mosi     <= mosi_nxt;
      sclk     <= sclk_nxt;
      busy     <= busy_nxt;
    end
  end

  // NOTE: every next-value signal is defaulted to its current value first so
  // no path through the case statement can infer a latch.
  always_comb begin
    state_nxt    = state;
    half_cnt_nxt = half_cnt;
    bit_cnt_nxt  = bit_cnt;
    gap_cnt_nxt  = gap_cnt;
    tx_sr_nxt    = tx_sr;
    rx_sr_nxt    = rx_sr;
    rx_data_nxt  = rx_data;
    mosi_nxt     = mosi;
    sclk_nxt     = sclk;
    busy_nxt     = busy;

    case (state)
      IDLE: begin
        sclk_nxt = 1'b0;
        mosi_nxt = 1'b0;
        busy_nxt = 1'b0;
        if (bus.getByte) begin
          tx_sr_nxt    = bus.sndData[6:0];
          mosi_nxt     = bus.sndData[7];
          busy_nxt     = 1'b1;
          half_cnt_nxt = '0;
          bit_cnt_nxt  = '0;
          state_nxt    = SHIFT;
        end
      end

      SHIFT: begin
        if (half_cnt == HALF_LAST) begin
          half_cnt_nxt = '0;
          sclk_nxt     = ~sclk;
          if (!sclk) begin
            rx_sr_nxt = {rx_sr[6:0], rx_bit};
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              // Byte complete: rx_sr already holds all eight captured bits.
              rx_data_nxt = rx_sr;
              mosi_nxt    = 1'b0;
              gap_cnt_nxt = '0;
              if (GAP_CYC == 0) begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
              end else begin
                state_nxt = GAP;
              end
            end else begin
              mosi_nxt  = tx_sr[6];
              tx_sr_nxt = {tx_sr[5:0], 1'b0};
            end
          end
        end else begin
          half_cnt_nxt = half_cnt + 1'b1;
        end
      end

      GAP: begin
        sclk_nxt = 1'b0;
        if (gap_cnt == GAP_LAST) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.BUSY   = busy;
  assign bus.RxData = rx_data;
  assign bus.MOSI   = mosi;
  assign bus.SCLK   = sclk;

endmodule

// File: tb/tb_spi_byte_engine.sv
// Randomized self-checking bench for spi_byte_engine: two instances (HALF_PER=1/GAP_CYC=1
// and HALF_PER=3/GAP_CYC=0) checked against a byte-level slave and timing model.
module tb_spi_byte_engine;

`ifdef SPI_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] rx_model [2];

  spi_byte_engine_if a_if ();
  spi_byte_engine_if b_if ();

  spi_byte_engine #(.HALF_PER(1), .GAP_CYC(1)) u_a (.CLK(clk), .RST(rst_n), .bus(a_if.slave));
  spi_byte_engine #(.HALF_PER(3), .GAP_CYC(0)) u_b (.CLK(clk), .RST(rst_n), .bus(b_if.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic get_busy(input int d);  return d ? b_if.BUSY : a_if.BUSY;     endfunction
  function automatic logic get_sclk(input int d);  return d ? b_if.SCLK : a_if.SCLK;     endfunction
  function automatic logic get_mosi(input int d);  return d ? b_if.MOSI : a_if.MOSI;     endfunction
  function automatic logic [7:0] get_rx(input int d); return d ? b_if.RxData : a_if.RxData; endfunction

  task automatic drive_req(input int d, input logic req, input logic [7:0] data);
    if (d != 0) begin b_if.getByte = req; b_if.sndData = data; end
    else        begin a_if.getByte = req; a_if.sndData = data; end
  endtask

  task automatic set_miso(input int d, input logic v);
    if (d != 0) b_if.MISO = v; else a_if.MISO = v;
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_busy"}, get_busy(d), 1'b0);
      check({tag, "_sclk"}, get_sclk(d), 1'b0);
      check({tag, "_mosi"}, get_mosi(d), 1'b0);
      check({tag, "_rx"},   get_rx(d),   8'h00);
    end
  endtask

  // One byte transfer on instance d; must be called at a negedge. The slave
  // model shifts slv out MSB-first, changing MISO after each SCLK fall.
  // keep leaves getByte high at the end so the next call tests the earliest restart.
  task automatic do_xfer(input int d, input logic [7:0] tx, input logic [7:0] slv,
                         input bit glitch, input bit keep);
    int h, g, n, rises, idx, busy_len;
    logic [7:0] mosi_byte, exp_rx;
    logic prev;
    bit done;
    h = (d != 0) ? 3 : 1;
    g = (d != 0) ? 0 : 1;
    exp_rx = LOOPBACK ? tx : slv;
    idx = 0;
    set_miso(d, slv[7]);
    drive_req(d, 1'b1, tx);
    @(posedge clk);
    n = 0; rises = 0; busy_len = 0; prev = 1'b0; mosi_byte = '0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (n == 0) check("accept", get_busy(d), 1'b1);
      if (get_sclk(d) && !prev) begin
        mosi_byte = {mosi_byte[6:0], get_mosi(d)};
        rises++;
      end
      if (!get_sclk(d) && prev && idx < 7) begin
        idx++;
        set_miso(d, slv[7-idx]);
      end
      prev = get_sclk(d);
      if (n == 16*h-1) check("rx_hold", get_rx(d), rx_model[d]);
      if (n == 16*h)   check("rx_update", get_rx(d), exp_rx);
      if (get_busy(d)) busy_len++; else done = 1'b1;
      if (glitch) begin
        if (n == 0) drive_req(d, 1'b0, tx);
        if (n == 2) drive_req(d, 1'b1, 8'hFF);
        if (n == 5) drive_req(d, 1'b0, 8'hFF);
        if (n == 7) drive_req(d, 1'b1, 8'h00);
        if (n == 9) drive_req(d, 1'b0, 8'h00);
      end else if (n == 0 && !keep) begin
        drive_req(d, 1'b0, $urandom_range(0, 255));
      end
      n++;
      if (n > 400 && !done) begin
        check("busy_timeout", get_busy(d), 1'b0);
        done = 1'b1;
      end
    end
    check("busy_len", busy_len, 16*h + g);
    check("sclk_rises", rises, 8);
    check("mosi_byte", mosi_byte, tx);
    rx_model[d] = exp_rx;
  endtask

  initial begin
    logic [7:0] seq_tx  [5] = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] seq_slv [5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    int rises;
    rx_model[0] = 8'h00;
    rx_model[1] = 8'h00;

    // Reset held with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req(0, 1'($urandom_range(0, 1)), 8'($urandom));
      drive_req(1, 1'($urandom_range(0, 1)), 8'($urandom));
      set_miso(0, 1'($urandom_range(0, 1)));
      set_miso(1, 1'($urandom_range(0, 1)));
      @(negedge clk);
      check_idle_outputs("reset");
    end
    drive_req(0, 1'b0, 8'h00);
    drive_req(1, 1'b0, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte
    do_xfer(0, 8'hA5, 8'h3C, 1'b0, 1'b0);

    // Controller-style sequence
    for (int i = 0; i < 5; i++) do_xfer(0, seq_tx[i], seq_slv[i], 1'b0, 1'b0);

    // Ignored getByte / sndData during SHIFT, then no spurious restart
    do_xfer(0, 8'h3C, 8'h99, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_restart", get_busy(0), 1'b0);
    end

    // Back-to-back with getByte held high
    do_xfer(0, 8'hC4, 8'h1E, 1'b0, 1'b1);
    do_xfer(0, 8'h2B, 8'hE7, 1'b0, 1'b0);

    // Abort after the 3rd SCLK rise
    set_miso(0, 1'b1);
    drive_req(0, 1'b1, 8'hF0);
    rises = 0;
    for (int i = 0; i < 40 && rises < 3; i++) begin
      @(negedge clk);
      drive_req(0, 1'b0, 8'hF0);
      if (a_if.SCLK && (i % 2 == 1)) rises++;
    end
    check("abort_reached", rises, 3);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    rx_model[0] = 8'h00;
    rx_model[1] = 8'h00;
    @(negedge clk);
    check_idle_outputs("abort_hold");
    rst_n = 1'b1;
    @(negedge clk);
    do_xfer(0, 8'h5A, 8'hC3, 1'b0, 1'b0);

    // Slow instance, zero gap, MISO tied high
    do_xfer(1, 8'h6E, 8'hFF, 1'b0, 1'b0);

    // Randomized traffic on both instances
    for (int i = 0; i < 20; i++) begin
      do_xfer($urandom_range(0, 1), 8'($urandom), 8'($urandom),
              1'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
